pbus_bridge: RTL and testbench

Registered bridge between the core's data-bus master port and the peripheral-bus interconnect (`pbus_conn`). It captures one core request, re-issues it as a single-cycle pulse on the peripheral bus, and waits for the slave response. It returns the registered response to the core and converts an unmapped-address decode or a hung slave into a faulting response. This breaks the combinational path from the core's address/data to the peripheral address decode.

---
 rtl/pbus_bridge_if.sv | 46 ++++
 rtl/pbus_bridge.sv | 193 +++++++++++++++++++
 tb/tb_pbus_bridge.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbus_bridge_if.sv
// Request/response bundle between the core data-bus port, pbus_bridge and pbus_conn.
// The slave modport is the bridge's view; master is the environment driving it.
interface pbus_bridge_if #(
  parameter int XLEN      = 32,
  parameter int BUS_WIDTH = 32,
  parameter int ACC_W     = 2
);
  logic                 h_req;
  logic [XLEN-1:0]      h_addr;
  logic                 h_w_rb;
  logic [ACC_W-1:0]     h_acc;
  logic [BUS_WIDTH-1:0] h_wdata;
  logic                 h_resp;
  logic [BUS_WIDTH-1:0] h_rdata;
  logic                 h_fault;
  logic                 h_busy;

  logic                 p_req;
  logic [XLEN-1:0]      p_addr;
  logic                 p_w_rb;
  logic [ACC_W-1:0]     p_acc;
  logic [BUS_WIDTH-1:0] p_wdata;
  logic                 p_resp;
  logic [BUS_WIDTH-1:0] p_rdata;
  logic                 p_fault;
  logic                 p_bus_fault;

  logic [XLEN-1:0]      err_addr;
  logic [1:0]           err_cause;

  modport slave (
    input  h_req, h_addr, h_w_rb, h_acc, h_wdata,
    output h_resp, h_rdata, h_fault, h_busy,
    output p_req, p_addr, p_w_rb, p_acc, p_wdata,
    input  p_resp, p_rdata, p_fault, p_bus_fault,
    output err_addr, err_cause
  );

  modport master (
    output h_req, h_addr, h_w_rb, h_acc, h_wdata,
    input  h_resp, h_rdata, h_fault, h_busy,
    input  p_req, p_addr, p_w_rb, p_acc, p_wdata,
    output p_resp, p_rdata, p_fault, p_bus_fault,
    input  err_addr, err_cause
  );
endinterface

// File: rtl/pbus_bridge.sv
// Registered core-to-peripheral bus bridge: h_req -> p_req pulse next cycle, h_resp 1 cycle after p_resp/p_bus_fault.
// One transaction in flight, core held off by h_busy; PBUS_BRIDGE_TIMEOUT_EN adds the hung-slave timeout.
module pbus_bridge #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned BUS_ACC_CNT = 4
) (
  input  logic           clk,
  input  logic           rstn,
  pbus_bridge_if.slave   bus
);
  localparam int unsigned ACC_W = $clog2(BUS_ACC_CNT);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_SLAVE  = 2'd1;
  localparam logic [1:0] CAUSE_DECODE = 2'd2;
  localparam logic [1:0] CAUSE_TMO    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [XLEN-1:0]      addr_q;
  logic                 w_rb_q;
  logic [ACC_W-1:0]     acc_q;
  logic [BUS_WIDTH-1:0] wdata_q;

  logic                 p_req_q;
  logic                 h_resp_q;
  logic                 h_fault_q;
  logic                 h_busy_q;
  logic [BUS_WIDTH-1:0] h_rdata_q;
  logic [XLEN-1:0]      err_addr_q;
  logic [1:0]           err_cause_q;

  logic                 cap;
  logic                 cap_fault;
  logic [BUS_WIDTH-1:0] cap_rdata;
  logic [1:0]           cap_cause;

  // Slave response as it would be captured: data only for clean reads.
  logic [BUS_WIDTH-1:0] slave_rdata;
  logic [1:0]           slave_cause;

  assign slave_rdata = (w_rb_q || bus.p_fault) ? '0 : bus.p_rdata;
  assign slave_cause = bus.p_fault ? CAUSE_SLAVE : CAUSE_NONE;

`ifdef PBUS_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  logic [15:0] cnt;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        expired;

  // cnt holds completed WAIT cycles; expiry fires once TIMEOUT full cycles have elapsed.
  assign expired = (cnt == TO_LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 16'd0;
    end else if (cnt_clr) begin
      cnt <= 16'd0;
    end else if (cnt_inc && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    cap_fault = 1'b0;
    cap_rdata = '0;
    cap_cause = CAUSE_NONE;
`ifdef PBUS_BRIDGE_TIMEOUT_EN
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.h_req) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.p_bus_fault) begin
          cap       = 1'b1;
          cap_fault = 1'b1;
          cap_cause = CAUSE_DECODE;
          state_nxt = RESP;
        end else if (bus.p_resp) begin
          cap       = 1'b1;
          cap_fault = bus.p_fault;
          cap_rdata = slave_rdata;
          cap_cause = slave_cause;
          state_nxt = RESP;
        end else begin
`ifdef PBUS_BRIDGE_TIMEOUT_EN
          cnt_clr   = 1'b1;
`endif
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.p_resp) begin
          cap       = 1'b1;
          cap_fault = bus.p_fault;
          cap_rdata = slave_rdata;
          cap_cause = slave_cause;
          state_nxt = RESP;
        end
`ifdef PBUS_BRIDGE_TIMEOUT_EN
        else if (expired) begin
          cap       = 1'b1;
          cap_fault = 1'b1;
          cap_cause = CAUSE_TMO;
          state_nxt = RESP;
        end else begin
          cnt_inc   = 1'b1;
        end
`endif
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      addr_q      <= '0;
      w_rb_q      <= 1'b0;
      acc_q       <= '0;
      wdata_q     <= '0;
      p_req_q     <= 1'b0;
      h_resp_q    <= 1'b0;
      h_fault_q   <= 1'b0;
      h_busy_q    <= 1'b0;
      h_rdata_q   <= '0;
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
    end else begin
      state    <= state_nxt;
      p_req_q  <= (state_nxt == ISSUE);
      h_busy_q <= (state_nxt != IDLE);
      h_resp_q <= cap;
      if ((state == IDLE) && bus.h_req) begin
        addr_q  <= bus.h_addr;
        w_rb_q  <= bus.h_w_rb;
        acc_q   <= bus.h_acc;
        wdata_q <= bus.h_wdata;
      end
      // Error log is sticky: only a faulting completion overwrites it.
      if (cap) begin
        h_rdata_q <= cap_rdata;
        h_fault_q <= cap_fault;
        if (cap_fault) begin
          err_addr_q  <= addr_q;
          err_cause_q <= cap_cause;
        end
      end
    end
  end

  assign bus.p_req     = p_req_q;
  assign bus.p_addr    = addr_q;
  assign bus.p_w_rb    = w_rb_q;
  assign bus.p_acc     = acc_q;
  assign bus.p_wdata   = wdata_q;
  assign bus.h_resp    = h_resp_q;
  assign bus.h_rdata   = h_rdata_q;
  assign bus.h_fault   = h_fault_q;
  assign bus.h_busy    = h_busy_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_cause = err_cause_q;

  a_timeout_range: assert property (@(posedge clk) (TIMEOUT >= 1) && (TIMEOUT <= 65535));
  a_preq_pulse:    assert property (@(posedge clk) disable iff (!rstn) p_req_q |=> !p_req_q);
  a_resp_pulse:    assert property (@(posedge clk) disable iff (!rstn) h_resp_q |=> !h_resp_q);
  a_resp_busy:     assert property (@(posedge clk) disable iff (!rstn) h_resp_q |-> h_busy_q);
endmodule

// File: tb/tb_pbus_bridge.sv
// Self-checking bench for pbus_bridge: directed scenarios plus randomized back-to-back traffic.
// Expected responses are derived from the transaction descriptor (latency k, fault flags), not from the FSM.
module tb_pbus_bridge;
  localparam int TO      = 4;
  localparam int XLEN    = 32;
  localparam int BW      = 32;
  localparam int ACC_CNT = 4;
  localparam int ACC_W   = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pbus_bridge_if #(.XLEN(XLEN), .BUS_WIDTH(BW), .ACC_W(ACC_W)) bus();

  pbus_bridge #(.TIMEOUT(TO), .XLEN(XLEN), .BUS_WIDTH(BW), .BUS_ACC_CNT(ACC_CNT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] m_err_addr;
  logic [1:0]      m_err_cause;

`ifdef PBUS_BRIDGE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  task automatic drive_idle();
    bus.h_req       = 1'b0;
    bus.h_addr      = '0;
    bus.h_w_rb      = 1'b0;
    bus.h_acc       = '0;
    bus.h_wdata     = '0;
    bus.p_resp      = 1'b0;
    bus.p_rdata     = '0;
    bus.p_fault     = 1'b0;
    bus.p_bus_fault = 1'b0;
  endtask

  // One transaction issued in its cycle 0. k = slave latency in cycles after ISSUE (p_resp at cycle 1+k).
  task automatic run_txn(input logic [XLEN-1:0] addr, input logic w_rb, input logic [ACC_W-1:0] acc,
                         input logic [BW-1:0] wdata, input int k, input bit bf, input bit pf,
                         input logic [BW-1:0] rdata, input bit spam, input string name);
    bit              tmo;
    int              exp_resp;
    int              last;
    bit              exp_fault;
    logic [1:0]      exp_cause;
    logic [BW-1:0]   exp_rdata;
    int              np, nr, first_preq, first_resp;
    logic [BW-1:0]   got_rdata;
    logic            got_fault;
    logic [XLEN-1:0] got_ea;
    logic [1:0]      got_ec;
    bit              stable, fields_ok, busy_ok;

    tmo       = TMO_EN && !bf && (k >= TO + 2);
    exp_resp  = bf ? 2 : (tmo ? 3 + TO : 2 + k);
    exp_fault = bf || tmo || pf;
    exp_cause = bf ? 2'd2 : (tmo ? 2'd3 : (pf ? 2'd1 : 2'd0));
    exp_rdata = (exp_fault || w_rb) ? '0 : rdata;
    if (exp_fault) begin
      m_err_addr  = addr;
      m_err_cause = exp_cause;
    end
    last = exp_resp;
    if (!bf && (1 + k > last)) last = 1 + k;

    np = 0; nr = 0; first_preq = -1; first_resp = -1;
    got_rdata = 'x; got_fault = 1'bx; got_ea = 'x; got_ec = 2'bxx;
    stable = 1'b1; fields_ok = 1'b0; busy_ok = 1'b0;

    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (bus.h_busy !== 1'b0 || bus.h_resp !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_at_start: busy=%b resp=%b required 0/0", name, bus.h_busy, bus.h_resp);
        end
      end
      if (bus.p_req === 1'b1) begin
        np++;
        if (first_preq < 0) first_preq = c;
      end
      if (bus.h_resp === 1'b1) begin
        nr++;
        if (first_resp < 0) begin
          first_resp = c;
          got_rdata  = bus.h_rdata;
          got_fault  = bus.h_fault;
          got_ea     = bus.err_addr;
          got_ec     = bus.err_cause;
        end
      end
      if (c == 1) begin
        fields_ok = (bus.p_addr === addr) && (bus.p_w_rb === w_rb) && (bus.p_acc === acc) && (bus.p_wdata === wdata);
        busy_ok   = (bus.h_busy === 1'b1);
      end
      if (c >= 1 && c <= exp_resp &&
          ({bus.p_addr, bus.p_w_rb, bus.p_acc, bus.p_wdata} !== {addr, w_rb, acc, wdata}))
        stable = 1'b0;

      bus.h_req       = (c == 0) || (spam && c >= 2 && c <= exp_resp);
      bus.h_addr      = (c == 0) ? addr  : XLEN'($urandom);
      bus.h_w_rb      = (c == 0) ? w_rb  : 1'($urandom);
      bus.h_acc       = (c == 0) ? acc   : ACC_W'($urandom);
      bus.h_wdata     = (c == 0) ? wdata : BW'($urandom);
      bus.p_bus_fault = bf && (c == 1);
      bus.p_resp      = !bf && (c == 1 + k);
      bus.p_rdata     = (c == 1 + k) ? rdata : BW'($urandom);
      bus.p_fault     = (c == 1 + k) ? pf : 1'($urandom);
    end

    checks++;
    if (np != 1 || first_preq != 1) begin
      errors++;
      $display("FAIL %s p_req: count=%0d first=%0d required count=1 first=1", name, np, first_preq);
    end
    checks++;
    if (!fields_ok) begin
      errors++;
      $display("FAIL %s p_fields: addr=%h w_rb=%b acc=%h required addr=%h w_rb=%b acc=%h", name,
               bus.p_addr, bus.p_w_rb, bus.p_acc, addr, w_rb, acc);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy_cycle1: h_busy not 1 at cycle 1", name);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s p_stable: p_* fields changed between ISSUE and RESP", name);
    end
    checks++;
    if (first_resp != exp_resp || nr != 1) begin
      errors++;
      $display("FAIL %s h_resp: cycle=%0d count=%0d required cycle=%0d count=1", name, first_resp, nr, exp_resp);
    end
    checks++;
    if (got_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s h_rdata: got %h required %h", name, got_rdata, exp_rdata);
    end
    checks++;
    if (got_fault !== exp_fault) begin
      errors++;
      $display("FAIL %s h_fault: got %b required %b", name, got_fault, exp_fault);
    end
    checks++;
    if (got_ea !== m_err_addr || got_ec !== m_err_cause) begin
      errors++;
      $display("FAIL %s err_log: addr=%h cause=%0d required addr=%h cause=%0d", name, got_ea, got_ec,
               m_err_addr, m_err_cause);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rstn = 1'b0;
    m_err_addr  = '0;
    m_err_cause = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.p_req, bus.h_resp, bus.h_fault, bus.h_busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: p_req/h_resp/h_fault/h_busy=%b required 0000",
               {bus.p_req, bus.h_resp, bus.h_fault, bus.h_busy});
    end
    checks++;
    if (bus.h_rdata !== '0 || bus.p_addr !== '0 || bus.p_wdata !== '0 || bus.p_w_rb !== 1'b0 || bus.p_acc !== '0) begin
      errors++;
      $display("FAIL reset_data: h_rdata=%h p_addr=%h p_wdata=%h required all 0", bus.h_rdata, bus.p_addr, bus.p_wdata);
    end
    checks++;
    if (bus.err_addr !== '0 || bus.err_cause !== 2'd0) begin
      errors++;
      $display("FAIL reset_err: err_addr=%h err_cause=%0d required 0/0", bus.err_addr, bus.err_cause);
    end
    rstn = 1'b1;
  endtask

  task automatic test_read_k2();
    run_txn(32'h1000_0010, 1'b0, 2'd2, 32'h0, 2, 1'b0, 1'b0, 32'h1234_5678, 1'b0, "read_k2");
  endtask

  task automatic test_write_k0();
    run_txn(32'h9000_0001, 1'b1, 2'd0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, "write_k0");
  endtask

  task automatic test_decode_fault();
    run_txn(32'h1234_0000, 1'b0, 2'd1, 32'h0, 0, 1'b1, 1'b0, 32'h5555_AAAA, 1'b0, "decode_fault");
  endtask

  task automatic test_timeout();
    if (TMO_EN) begin
      // No response until cycle 9: timeout at cycle 7, the late p_resp is dropped.
      run_txn(32'h2000_0040, 1'b0, 2'd2, 32'h0, 8, 1'b0, 1'b0, 32'h7777_0000, 1'b0, "timeout");
      run_txn(32'h2000_0080, 1'b0, 2'd2, 32'h0, TO + 1, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, "resp_vs_expiry");
      run_txn(32'h2000_00C0, 1'b1, 2'd3, 32'h1, TO + 2, 1'b0, 1'b0, 32'h0, 1'b0, "timeout_resp_cycle");
    end else begin
      run_txn(32'h2000_0040, 1'b0, 2'd2, 32'h0, 40, 1'b0, 1'b0, 32'h7777_0000, 1'b0, "long_wait");
    end
  endtask

  task automatic test_slave_fault();
    run_txn(32'h4000_0100, 1'b0, 2'd2, 32'h0, 1, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0, "slave_fault");
    run_txn(32'h4000_0200, 1'b0, 2'd2, 32'h0, 3, 1'b0, 1'b0, 32'h0102_0304, 1'b0, "clean_after_fault");
  endtask

  task automatic test_hreq_in_wait();
    run_txn(32'h5000_0000, 1'b1, 2'd1, 32'hA5A5_5A5A, 3, 1'b0, 1'b0, 32'h0, 1'b1, "hreq_in_wait");
  endtask

  task automatic test_reset_mid_wait();
    int nresp;
    @(negedge clk);
    bus.h_req = 1'b1; bus.h_addr = 32'h6000_0004; bus.h_w_rb = 1'b1; bus.h_acc = 2'd2; bus.h_wdata = 32'h1111_2222;
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.p_req, bus.h_resp, bus.h_fault, bus.h_busy} !== 4'b0 || bus.p_addr !== '0 ||
        bus.p_wdata !== '0 || bus.err_addr !== '0 || bus.err_cause !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: busy=%b p_addr=%h p_wdata=%h required all 0", bus.h_busy, bus.p_addr, bus.p_wdata);
    end
    m_err_addr  = '0;
    m_err_cause = 2'd0;
    @(negedge clk);
    rstn = 1'b1;
    nresp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.h_resp === 1'b1 || bus.h_busy === 1'b1) nresp++;
      bus.p_resp  = (c == 2);
      bus.p_rdata = 32'h9999_9999;
    end
    drive_idle();
    checks++;
    if (nresp != 0) begin
      errors++;
      $display("FAIL reset_no_resp: %0d cycles with h_resp/h_busy after reset, required 0", nresp);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [XLEN-1:0] a;
      int              k;
      bit              bf, pf;
      a  = $urandom;
      k  = TMO_EN ? int'($urandom_range(0, TO + 4)) : int'($urandom_range(0, 6));
      bf = ($urandom_range(0, 5) == 0);
      pf = ($urandom_range(0, 4) == 0);
      run_txn(a, 1'($urandom), ACC_W'($urandom), BW'($urandom), k, bf, pf, BW'($urandom),
              1'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_read_k2();
    test_write_k0();
    test_decode_fault();
    test_timeout();
    test_slave_fault();
    test_hreq_in_wait();
    test_reset_mid_wait();
    test_back_to_back();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
